dcp_dump: RTL and testbench
===========================

Name: dcp_dump

Overview:
- Debug-console command processor that dumps a block of NUM_WORDS consecutive register-file/memory words over the TX channel.
- Generalised successor of the single-word read command, with parametrised address/data width, word count, address stride and read latency.
- Sits beside the other DCP command units, activated when sel_mode equals cmd_code, sharing the RX scanner and TX printer handshakes.

Parameters:
AW, 32, address width (AW <= TXW)
DW, 32, read-data width (DW <= TXW)
TXW, 32, TX/RX word width
NUM_WORDS, 4, words dumped per command (1..255)
ADDR_STEP, 1, address increment per word
RD_LAT, 1, cycles from addr change to valid dout_rf (0..7)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
sel_mode  in  8  currently selected command code
cmd_code  in  8  code this unit answers to
finish  out  1  dump complete, held while still selected
din_rx  in  TXW  scanned hex value from RX
req_rx  out  1  scan request
type_rx  out  1  scan type, 1 = hex word
flag_rx  in  1  1 = empty input (no value typed)
ack_rx  in  1  scan done
req_tx  out  1  print request
type_tx  out  1  0 = byte/char, 1 = hex word
ack_tx  in  1  print done
addr  out  AW  read address to register file/memory
dout_rf  in  DW  read data
dout  out  TXW  value to print
cs  out  8  {4'b0, state} debug view

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low on rstn. On reset all outputs = 0, state = IDLE, last_addr = 0, word and item counters = 0.
- Deselect: sel_mode != cmd_code in any state forces state IDLE on the next edge. In IDLE, req_rx, req_tx, finish, type_*, dout and addr are cleared and counters zeroed; last_addr is kept.
- States (4-bit encoding): IDLE=0, SCAN=1, WAITS=2, RD=3, WAITRD=4, PRINT=5, WAITP=6, NEXT=7, DONE=8.
- IDLE -> SCAN when selected.
- SCAN: req_rx=1, type_rx=1. Always -> WAITS.
- WAITS: hold req_rx until ack_rx=1; that cycle req_rx<=0.
  - flag_rx=0: last_addr <= din_rx[AW-1:0].
  - flag_rx=1: last_addr unchanged.
  - Then -> RD with word counter w=0.
- RD: addr <= last_addr + w*ADDR_STEP (mod 2^AW); reset latency counter. -> WAITRD.
- WAITRD: count RD_LAT cycles (RD_LAT=0 leaves after one cycle). On exit, capture dout_rf into data register and set item i=0. -> PRINT.
- PRINT: req_tx<=1, then -> WAITP. dout/type_tx by item:
  - i=0: dout = zero-extended addr, type_tx=1.
  - i=1: dout = zero-extended captured data, type_tx=1.
  - i=2: dout = 8'h0A zero-extended, type_tx=0.
- WAITP: hold req_tx and dout until ack_tx=1; that cycle req_tx<=0.
  - i<2: i<=i+1, -> PRINT.
  - i=2: -> NEXT.
- NEXT:
  - w < NUM_WORDS-1: w<=w+1, -> RD.
  - else last_addr <= last_addr + NUM_WORDS*ADDR_STEP (mod 2^AW), -> DONE.
- DONE: finish=1; stay while selected; no further requests. Re-running requires deselect then reselect.
- Handshake rules:
  - req_* rises at most once per transfer.
  - dout/type_tx stable from req_tx rise until the ack cycle.
  - ack arriving while no request is pending is ignored.
  - ack_rx and ack_tx are level-sampled only in their WAIT states.
- Address wraps modulo 2^AW both within a dump and in last_addr.
- Deselect mid-transfer aborts immediately, req dropped in IDLE. last_addr keeps any value already scanned but is not advanced.

Test Plan:
1. Reset, select cmd_code=8'h44, scan din_rx=32'h10 with flag_rx=0, NUM_WORDS=4, ADDR_STEP=1 -> 12 prints in order (addr 10, data, 0A)... up to addr 13. finish=1 held; last_addr=32'h14.
2. Deselect, reselect, scan with flag_rx=1 -> dump starts at 32'h14, prints addresses 14..17; last_addr=32'h18.
3. Scan din_rx=32'hFFFFFFFE, ADDR_STEP=1 -> addresses FFFFFFFE, FFFFFFFF, 0, 1; last_addr=32'h2.
4. RD_LAT=3 with a model updating dout_rf 3 cycles after addr -> printed data equals model value (e.g. 32'hDEADBEEF at addr 10), not stale data.
5. ack_tx delayed 20 cycles -> req_tx, dout and type_tx remain stable for all 20 cycles; a spurious ack_tx while in RD has no effect.
6. sel_mode changed while in WAITP of word 2 -> IDLE next cycle, req_tx=0, finish=0; last_addr keeps its scanned value and is not advanced.

Source files
------------

// File: rtl/dcp_dump.sv
// Debug-console block dump: scans a start address, then prints NUM_WORDS
// lines of "address, data, newline" over the TX channel.
module dcp_dump #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TXW       = 32,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_STEP = 1,
  parameter int RD_LAT    = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [7:0]     sel_mode,
  input  logic [7:0]     cmd_code,
  output logic           finish,
  input  logic [TXW-1:0] din_rx,
  output logic           req_rx,
  output logic           type_rx,
  input  logic           flag_rx,
  input  logic           ack_rx,
  output logic           req_tx,
  output logic           type_tx,
  input  logic           ack_tx,
  output logic [AW-1:0]  addr,
  input  logic [DW-1:0]  dout_rf,
  output logic [TXW-1:0] dout,
  output logic [7:0]     cs
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SCAN   = 4'd1,
    WAITS  = 4'd2,
    RD     = 4'd3,
    WAITRD = 4'd4,
    PRINT  = 4'd5,
    WAITP  = 4'd6,
    NEXT   = 4'd7,
    DONE   = 4'd8
  } state_t;

  localparam logic [AW-1:0] STEP   = AW'(ADDR_STEP);
  localparam logic [AW-1:0] SPAN   = AW'(NUM_WORDS * ADDR_STEP);
  localparam logic [7:0]    LAST_W = 8'(NUM_WORDS - 1);
  localparam logic [2:0]    LAT    = 3'(RD_LAT);

  state_t          state;
  logic [AW-1:0]   last_addr;
  logic [7:0]      word_cnt;
  logic [1:0]      item;
  logic [2:0]      lat_cnt;
  logic [DW-1:0]   data_q;
  logic            selected;

  assign selected = (sel_mode == cmd_code);
  assign cs       = {4'b0, state};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      last_addr <= '0;
      word_cnt  <= '0;
      item      <= '0;
      lat_cnt   <= '0;
      data_q    <= '0;
      finish    <= 1'b0;
      req_rx    <= 1'b0;
      type_rx   <= 1'b0;
      req_tx    <= 1'b0;
      type_tx   <= 1'b0;
      addr      <= '0;
      dout      <= '0;
    end else if (!selected || state == IDLE) begin
      // Deselect aborts from any state; last_addr survives so a later
      // empty scan continues from the last scanned/advanced address.
      state    <= selected ? SCAN : IDLE;
      word_cnt <= '0;
      item     <= '0;
      lat_cnt  <= '0;
      finish   <= 1'b0;
      req_rx   <= 1'b0;
      type_rx  <= 1'b0;
      req_tx   <= 1'b0;
      type_tx  <= 1'b0;
      addr     <= '0;
      dout     <= '0;
    end else begin
      case (state)
        SCAN: begin
          req_rx  <= 1'b1;
          type_rx <= 1'b1;
          state   <= WAITS;
        end
        WAITS: begin
          if (ack_rx) begin
            req_rx <= 1'b0;
            if (!flag_rx)
              last_addr <= din_rx[AW-1:0];
            word_cnt <= '0;
            state    <= RD;
          end
        end
        RD: begin
          addr    <= last_addr + AW'(word_cnt) * STEP;
          lat_cnt <= '0;
          state   <= WAITRD;
        end
        WAITRD: begin
          if (lat_cnt == LAT) begin
            data_q <= dout_rf;
            item   <= '0;
            state  <= PRINT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        PRINT: begin
          req_tx <= 1'b1;
          case (item)
            2'd0: begin
              dout    <= TXW'(addr);
              type_tx <= 1'b1;
            end
            2'd1: begin
              dout    <= TXW'(data_q);
              type_tx <= 1'b1;
            end
            default: begin
              dout    <= TXW'(8'h0A);
              type_tx <= 1'b0;
            end
          endcase
          state <= WAITP;
        end
        WAITP: begin
          if (ack_tx) begin
            req_tx <= 1'b0;
            if (item < 2'd2) begin
              item  <= item + 2'd1;
              state <= PRINT;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (word_cnt < LAST_W) begin
            word_cnt <= word_cnt + 8'd1;
            state    <= RD;
          end else begin
            last_addr <= last_addr + SPAN;
            state     <= DONE;
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcp_dump.sv
// Directed + randomized bench for dcp_dump with a 3-cycle-latency memory model.
module tb_dcp_dump;

  localparam logic [7:0] CMD = 8'h44;
  localparam int         NW  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  sel_mode = 8'h00;
  logic [7:0]  cmd_code = CMD;
  logic        finish;
  logic [31:0] din_rx = '0;
  logic        req_rx, type_rx;
  logic        flag_rx = 1'b0;
  logic        ack_rx = 1'b0;
  logic        req_tx, type_tx;
  logic        ack_tx = 1'b0;
  logic [31:0] addr;
  logic [31:0] dout_rf;
  logic [31:0] dout;
  logic [7:0]  cs;

  always #5 clk = ~clk;

  dcp_dump #(
    .AW(32), .DW(32), .TXW(32), .NUM_WORDS(NW), .ADDR_STEP(1), .RD_LAT(3)
  ) dut (
    .clk(clk), .rstn(rstn), .sel_mode(sel_mode), .cmd_code(cmd_code),
    .finish(finish), .din_rx(din_rx), .req_rx(req_rx), .type_rx(type_rx),
    .flag_rx(flag_rx), .ack_rx(ack_rx), .req_tx(req_tx), .type_tx(type_tx),
    .ack_tx(ack_tx), .addr(addr), .dout_rf(dout_rf), .dout(dout), .cs(cs)
  );

  logic [31:0] seed;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ seed ^ {a[15:0], a[31:16]};
  endfunction

  // Memory whose read data appears three clock edges after the address.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1      <= mem_f(addr);
    p2      <= p1;
    dout_rf <= p2;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_last = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = req_rx, 1 = req_tx, 2 = finish
  task automatic wait_high(input string tag, input int which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ((which == 0 && req_rx) || (which == 1 && req_tx) || (which == 2 && finish)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_dump(input logic [31:0] din, input bit flag,
                          input int abort_w, input int long_w, input int spur_w);
    bit          ok;
    logic [31:0] start, a, exp_d;
    bit          exp_t;
    int          hold;
    sel_mode = 8'h00;
    tick();
    chk("idle_outputs", {29'd0, finish, req_tx, req_rx, cs, dout}, 64'd0);
    chk("idle_addr", {32'd0, addr}, 64'd0);
    sel_mode = CMD;
    wait_high("req_rx", 0, ok);
    if (!ok) return;
    chk("type_rx", {63'd0, type_rx}, 64'd1);
    din_rx = din; flag_rx = flag; ack_rx = 1'b1;
    tick();
    ack_rx = 1'b0; din_rx = $urandom; flag_rx = $urandom_range(0, 1);
    chk("req_rx_drop", {63'd0, req_rx}, 64'd0);
    if (!flag) model_last = din;
    start = model_last;
    for (int w = 0; w < NW; w++) begin
      a = start + 32'(w);
      for (int i = 0; i < 3; i++) begin
        exp_d = (i == 0) ? a : (i == 1) ? mem_f(a) : 32'h0A;
        exp_t = (i != 2);
        wait_high("req_tx", 1, ok);
        if (!ok) return;
        chk("print_dout", {32'd0, dout}, {32'd0, exp_d});
        chk("print_type", {63'd0, type_tx}, {63'd0, exp_t});
        if (w == abort_w && i == 1) begin
          sel_mode = 8'h00;
          tick();
          chk("abort_state", {53'd0, req_tx, finish, cs}, 64'd0);
          return;
        end
        hold = (w == long_w && i == 1) ? 20 : int'($urandom_range(0, 2));
        for (int h = 0; h < hold; h++) begin
          tick();
          chk("hold_stable", {30'd0, req_tx, type_tx, dout}, {30'd0, 1'b1, exp_t, exp_d});
        end
        ack_tx = 1'b1;
        tick();
        chk("req_tx_drop", {63'd0, req_tx}, 64'd0);
        if (w == spur_w && i == 2) begin
          for (int s = 0; s < 3; s++) begin
            tick();
            chk("spurious_ack", {63'd0, req_tx}, 64'd0);
          end
        end
        ack_tx = 1'b0;
      end
    end
    model_last = start + 32'(NW);
    wait_high("finish", 2, ok);
    if (!ok) return;
    chk("done_cs", {56'd0, cs}, 64'd8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_hold", {61'd0, finish, req_rx, req_tx}, 64'd4);
    end
  endtask

  initial begin
    seed = $urandom;
    #2 rstn = 1'b0;
    tick();
    chk("reset_ctrl", {50'd0, req_rx, type_rx, req_tx, type_tx, finish, 1'b0, cs}, 64'd0);
    chk("reset_data", {dout, addr}, 64'd0);
    sel_mode = CMD;
    tick();
    chk("reset_held", {55'd0, req_rx, cs}, 64'd0);
    sel_mode = 8'h00;
    rstn = 1'b1;
    tick();

    run_dump(32'h10, 1'b0, -1, 1, 0);           // 10..13, long ack + spurious ack
    run_dump($urandom, 1'b1, -1, -1, -1);       // continues at 14
    run_dump(32'hFFFF_FFFE, 1'b0, -1, -1, 2);   // wraps through zero
    run_dump($urandom, 1'b1, -1, -1, -1);       // continues at 2
    for (int k = 0; k < 4; k++)
      run_dump($urandom, 1'($urandom_range(0, 1)), -1, -1, -1);
    run_dump(32'h100, 1'b0, 2, -1, -1);         // aborted at word 2
    run_dump($urandom, 1'b1, -1, -1, -1);       // restarts at 100, not advanced

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
